// File: rtl/data_mem_stage_pkg.sv
// Shared types and constants for the memory-access / write-back stage.
package data_mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Bit positions inside the 9-bit main CONTROL code.
    localparam int CTL_W          = 9;
    localparam int CTL_REG_DST    = 8;
    localparam int CTL_ALU_SRC    = 7;
    localparam int CTL_MEM_TO_REG = 6;
    localparam int CTL_REG_WRITE  = 5;
    localparam int CTL_MEM_READ   = 4;
    localparam int CTL_MEM_WRITE  = 3;
    localparam int CTL_BRANCH     = 2;
    localparam int CTL_ALU_OP1    = 1;
    localparam int CTL_ALU_OP0    = 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WB     = 2'd2
    } state_e;

    // Fields captured at the input handshake.
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] sdata;
        logic [REG_W-1:0]  wreg;
        logic              mem_rd;
        logic              mem_wr;
        logic              mem_to_reg;
        logic              reg_wr;
        logic              misalign;
    } req_t;

endpackage

// File: rtl/dmem_array.sv
// Byte-addressed data memory: synchronous big-endian 32-bit write, combinational 32-bit read.
module dmem_array
    import data_mem_stage_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Not reset: contents survive RESET by design.
    logic [7:0] mem_q [MEM_BYTES];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i]          <= wdata_i[31:24];
            mem_q[addr_i + AW'(1)] <= wdata_i[23:16];
            mem_q[addr_i + AW'(2)] <= wdata_i[15:8];
            mem_q[addr_i + AW'(3)] <= wdata_i[7:0];
        end
    end

    assign rdata_o = {mem_q[addr_i], mem_q[addr_i + AW'(1)],
                      mem_q[addr_i + AW'(2)], mem_q[addr_i + AW'(3)]};

endmodule

// File: rtl/data_mem_stage.sv
// Memory-access and write-back stage feeding the register file write port.
// Optional misaligned-access trap enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_stage
    import data_mem_stage_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int MEM_LAT   = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [REG_W-1:0]  WriteRegIn,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWriteIn,
    output logic [DATA_W-1:0] WriteData,
    output logic [REG_W-1:0]  WriteReg,
    output logic              RegWrite,
    output logic              AlignErr
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [REG_W-1:0]  wreg_q, wreg_d;
    logic              regwr_q, regwr_d;
    logic              aerr_q, aerr_d;
    logic              in_mis;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_rdata;

`ifdef DMEM_ALIGN_CHECK_EN
    assign in_mis = (MemRead | MemWrite) && (ALUOut[1:0] != 2'b00);
`else
    assign in_mis = 1'b0;
`endif

    // Index wraps modulo MEM_BYTES and is forced word aligned.
    assign mem_addr = req_q.addr[AW-1:0] & ~AW'(3);

    dmem_array #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (req_q.sdata),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        wreg_d  = wreg_q;
        regwr_d = 1'b0;
        aerr_d  = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    req_d = '{addr: ALUOut, sdata: StoreData, wreg: WriteRegIn,
                              mem_rd: MemRead, mem_wr: MemWrite,
                              mem_to_reg: MemtoReg, reg_wr: RegWriteIn,
                              misalign: in_mis};
                    // Cleared so a store-only op with MemtoReg writes back 0.
                    rdata_d = '0;
                    if ((MemRead | MemWrite) && !in_mis) begin
                        state_d = S_ACCESS;
                        cnt_d   = CW'(MEM_LAT - 1);
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    if (req_q.mem_wr) mem_we = 1'b1;
                    else              rdata_d = mem_rdata;
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WB: begin
                wdata_d = req_q.mem_to_reg ? rdata_q : req_q.addr;
                wreg_d  = req_q.wreg;
                regwr_d = req_q.reg_wr & ~req_q.misalign;
                aerr_d  = req_q.misalign;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            wreg_q  <= '0;
            regwr_q <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            wreg_q  <= wreg_d;
            regwr_q <= regwr_d;
            aerr_q  <= aerr_d;
        end
    end

    assign InReady   = (state_q == S_IDLE);
    assign WriteData = wdata_q;
    assign WriteReg  = wreg_q;
    assign RegWrite  = regwr_q;
    assign AlignErr  = aerr_q;

endmodule
